mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between three requesters: instruction fetch, load buffer and store commit.
- Serialises each 1/2/4-byte access into byte beats and assembles little-endian read words, sign- or zero-extended.
- Returns a one-cycle done pulse to the requester.
- Sits between the fetch/lbuffer/ROB side and the top-level RAM/IO bus. Replaces the requester-facing role of datactrl.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, requester data width.
- IO_BASE_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  clock; all state changes on the rising edge.
- rst_in  in  1  synchronous reset, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- rob_rst_in  in  1  misprediction flush.
- ifetch_en_in  in  1  fetch request; held high until ifetch_done_out.
- ifetch_addr_in  in  32  fetch address, 4-byte unsigned read.
- ifetch_done_out  out  1  one-cycle pulse; data valid.
- ifetch_data_out  out  32  fetched word.
- lbuffer_en_in  in  1  load request; held until done.
- lbuffer_addr_in  in  32  load address.
- lbuffer_width_in  in  3  3'b001/010/100 = 1/2/4 bytes; any other value is treated as 4.
- lbuffer_sgn_in  in  1  1 = sign-extend.
- lbuffer_done_out  out  1  one-cycle pulse.
- lbuffer_data_out  out  32  extended load result.
- store_en_in  in  1  committed store request; held until done.
- store_addr_in  in  32  store address.
- store_width_in  in  3  same encoding as load.
- store_data_in  in  32  store data; low bytes used first.
- store_done_out  out  1  one-cycle pulse.
- io_buffer_full_in  in  1  UART buffer full.
- mem_a_out  out  32  RAM byte address.
- mem_dout  out  8  write byte.
- mem_din  in  8  read byte; valid the cycle after its address is driven.
- mem_wr_out  out  1  1 = write beat.

Behaviour:
- Reset (rst_in==0 at an edge):
  - state=IDLE.
  - All done pulses 0, all data outputs 0.
  - mem_a_out=0, mem_wr_out=0.
- rdy_in==0: hold every register; mem_wr_out forced 0.
- States: IDLE, READ, WRITE, WAIT_IO.
- IDLE arbitration, fixed priority store > load > fetch:
  - The winner's address, width, sign and data are latched at grant.
  - Requester inputs are ignored afterwards.
  - Grant goes to WRITE (store) or READ (load/fetch).
- READ of W bytes, grant edge = t:
  - Addresses a, a+1 … a+W-1 are driven in cycles t+1 … t+W.
  - Byte k is captured from mem_din one cycle after its address is driven.
  - Done pulse and data are registered in cycle t+W+2.
  - Then back to IDLE; the next grant is possible in that same cycle.
  - Data: byte0 in bits [7:0]. Upper bits are filled with bit 8W-1 when sgn=1, else 0.
- WRITE of W bytes:
  - Beats in cycles t+1 … t+W with mem_wr_out=1 and mem_dout = data[8k+7:8k].
  - store_done_out pulses in cycle t+W+1.
- mem_wr_out is 0 whenever not in a write beat. mem_a_out holds its last value when idle.
- Done pulses are exactly one cycle. At most one done output is high in any cycle.
- rob_rst_in high at an edge:
  - Aborts an in-flight READ (load or fetch); no done pulse is issued.
  - State goes to IDLE and any captured bytes are discarded.
  - Load/fetch requests sampled in IDLE that same edge are not granted.
  - WRITE is never aborted; the store completes and pulses done.
- Requester drop: a requester dropping en mid-access is not supported. Behaviour is unchanged and the done pulse is still issued.
- Address increment wraps modulo 2^32.

Optional Feature:
- Macro: MEM_ARBITER_IO_STALL_EN.
- Defined:
  - A store with addr[17:16]==IO_BASE_HI checks io_buffer_full_in before each beat.
  - If it is high, enter WAIT_IO with mem_wr_out=0 and stay until it is low.
  - Then issue the beat; each stall cycle adds one cycle to done latency.
  - rob_rst_in does not abort WAIT_IO.
- Undefined: io_buffer_full_in is ignored, WAIT_IO is unreachable, and IO stores use normal WRITE timing.

Test Plan:
1. LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, grant at t → lbuffer_done_out at t+6, data 0x12345678; mem_wr_out stays 0.
2. LB sgn=1 at byte 0x80 → 0xFFFFFF80. LHU at halfword 0x8001 → 0x00008001. LH at 0x8001 → 0xFFFF8001.
3. store_en, lbuffer_en, ifetch_en all raised the same cycle → order store, load, fetch. Each done pulse occurs exactly once; no overlap.
4. SW 0xDEADBEEF at 0x200 → beats 0x200:EF, 0x201:BE, 0x202:AD, 0x203:DE; store_done_out at t+5.
5. Fetch in READ, rob_rst_in pulsed at t+2 → no ifetch_done_out; IDLE next cycle; a pending store is granted afterwards. Same flush during a store → store completes normally.
6. With MEM_ARBITER_IO_STALL_EN: SB to 0x30000 with io_buffer_full_in high for 3 cycles → mem_wr_out stays 0 during those cycles; the beat follows; done delayed by 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: store > load > fetch, serialises 1/2/4-byte
// accesses into byte beats and returns little-endian, extended read words.
//
// Ports: clk_in, rst_in (sync, active-low), rdy_in (global enable),
//   rob_rst_in (flush, aborts reads only),
//   ifetch_*   : 4-byte unsigned fetch, done pulse + word,
//   lbuffer_*  : 1/2/4-byte load with sign select, done pulse + word,
//   store_*    : 1/2/4-byte store, done pulse,
//   io_buffer_full_in : UART full flag,
//   mem_a_out/mem_dout/mem_din/mem_wr_out : byte RAM bus (1-cycle read).
// Optional build macro MEM_ARBITER_IO_STALL_EN: stores into the IO region
//   stall in WAIT_IO while io_buffer_full_in is high.

module mem_arbiter #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_rst_in,
    input  logic              ifetch_en_in,
    input  logic [ADDR_W-1:0] ifetch_addr_in,
    output logic              ifetch_done_out,
    output logic [DATA_W-1:0] ifetch_data_out,
    input  logic              lbuffer_en_in,
    input  logic [ADDR_W-1:0] lbuffer_addr_in,
    input  logic [2:0]        lbuffer_width_in,
    input  logic              lbuffer_sgn_in,
    output logic              lbuffer_done_out,
    output logic [DATA_W-1:0] lbuffer_data_out,
    input  logic              store_en_in,
    input  logic [ADDR_W-1:0] store_addr_in,
    input  logic [2:0]        store_width_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              store_done_out,
    input  logic              io_buffer_full_in,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic              mem_wr_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT_IO} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [2:0]        nbytes;
    logic [2:0]        cnt;
    logic [2:0]        cnt_m2;
    logic              sgn_r;
    logic              fetch_r;
    logic              wr_q;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] rnext;
    logic [DATA_W-1:0] rword;
    logic              gnt_st;
    logic              gnt_ld;
    logic              gnt_if;

    function automatic logic [2:0] width_bytes(input logic [2:0] w);
        logic [2:0] n;
        case (w)
            3'b001:  n = 3'd1;
            3'b010:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [DATA_W-1:0] extend(
        input logic [DATA_W-1:0] b,
        input logic [2:0]        n,
        input logic              s
    );
        logic [DATA_W-1:0] r;
        case (n)
            3'd1:    r = {{(DATA_W-8){s & b[7]}}, b[7:0]};
            3'd2:    r = {{(DATA_W-16){s & b[15]}}, b[15:0]};
            default: r = b;
        endcase
        return r;
    endfunction

    // A flush blocks new reads in the same edge; stores still win.
    assign gnt_st = store_en_in;
    assign gnt_ld = lbuffer_en_in & ~store_en_in & ~rob_rst_in;
    assign gnt_if = ifetch_en_in & ~store_en_in & ~lbuffer_en_in
                  & ~rob_rst_in;

    // Byte j arrives on mem_din two READ edges after its address beat,
    // so the final byte is merged combinationally into the done word.
    always_comb begin
        cnt_m2 = cnt - 3'd2;
        rnext  = rbuf;
        if (cnt >= 3'd2)
            rnext[{cnt_m2[1:0], 3'b000} +: 8] = mem_din;
        rword = extend(rnext, nbytes, sgn_r);
    end

    assign mem_wr_out = wr_q & rdy_in;

`ifdef MEM_ARBITER_IO_STALL_EN
    logic is_io;
    logic stall;
    assign stall = is_io & io_buffer_full_in;
`else
    logic unused_io;
    assign unused_io = io_buffer_full_in ^ (^IO_BASE_HI);
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            ptr              <= '0;
            nbytes           <= '0;
            cnt              <= '0;
            sgn_r            <= 1'b0;
            fetch_r          <= 1'b0;
            wr_q             <= 1'b0;
            wdata            <= '0;
            rbuf             <= '0;
            mem_a_out        <= '0;
            mem_dout         <= '0;
            ifetch_done_out  <= 1'b0;
            ifetch_data_out  <= '0;
            lbuffer_done_out <= 1'b0;
            lbuffer_data_out <= '0;
            store_done_out   <= 1'b0;
`ifdef MEM_ARBITER_IO_STALL_EN
            is_io            <= 1'b0;
`endif
        end else if (rdy_in) begin
            ifetch_done_out  <= 1'b0;
            lbuffer_done_out <= 1'b0;
            store_done_out   <= 1'b0;
            unique case (state)
                IDLE: begin
                    wr_q <= 1'b0;
                    cnt  <= 3'd0;
                    unique case (1'b1)
                        gnt_st: begin
                            ptr    <= store_addr_in;
                            nbytes <= width_bytes(store_width_in);
                            wdata  <= store_data_in;
                            sgn_r  <= 1'b0;
                            state  <= WRITE;
`ifdef MEM_ARBITER_IO_STALL_EN
                            is_io  <= store_addr_in[17:16] == IO_BASE_HI;
`endif
                        end
                        gnt_ld: begin
                            ptr     <= lbuffer_addr_in;
                            nbytes  <= width_bytes(lbuffer_width_in);
                            sgn_r   <= lbuffer_sgn_in;
                            fetch_r <= 1'b0;
                            state   <= READ;
                        end
                        gnt_if: begin
                            ptr     <= ifetch_addr_in;
                            nbytes  <= 3'd4;
                            sgn_r   <= 1'b0;
                            fetch_r <= 1'b1;
                            state   <= READ;
                        end
                        default: ;
                    endcase
                end
                READ: begin
                    if (rob_rst_in) begin
                        state <= IDLE;
                    end else begin
                        if (cnt < nbytes) begin
                            mem_a_out <= ptr;
                            ptr       <= ptr + ADDR_W'(1);
                        end
                        rbuf <= rnext;
                        if (cnt == nbytes + 3'd1) begin
                            state <= IDLE;
                            if (fetch_r) begin
                                ifetch_done_out <= 1'b1;
                                ifetch_data_out <= rword;
                            end else begin
                                lbuffer_done_out <= 1'b1;
                                lbuffer_data_out <= rword;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == nbytes) begin
                        wr_q           <= 1'b0;
                        store_done_out <= 1'b1;
                        state          <= IDLE;
`ifdef MEM_ARBITER_IO_STALL_EN
                    end else if (stall) begin
                        wr_q  <= 1'b0;
                        state <= WAIT_IO;
`endif
                    end else begin
                        mem_a_out <= ptr;
                        ptr       <= ptr + ADDR_W'(1);
                        mem_dout  <= wdata[7:0];
                        wdata     <= wdata >> 8;
                        wr_q      <= 1'b1;
                        cnt       <= cnt + 3'd1;
                    end
                end
`ifdef MEM_ARBITER_IO_STALL_EN
                WAIT_IO: begin
                    if (!io_buffer_full_in) begin
                        mem_a_out <= ptr;
                        ptr       <= ptr + ADDR_W'(1);
                        mem_dout  <= wdata[7:0];
                        wdata     <= wdata >> 8;
                        wr_q      <= 1'b1;
                        cnt       <= cnt + 3'd1;
                        state     <= WRITE;
                    end
                end
`endif
                default: begin
                    wr_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus flush, priority,
// freeze and IO-stall sequences against a 64 KiB byte RAM model.

module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_rst_in;
    logic        ifetch_en_in;
    logic [31:0] ifetch_addr_in;
    logic        ifetch_done_out;
    logic [31:0] ifetch_data_out;
    logic        lbuffer_en_in;
    logic [31:0] lbuffer_addr_in;
    logic [2:0]  lbuffer_width_in;
    logic        lbuffer_sgn_in;
    logic        lbuffer_done_out;
    logic [31:0] lbuffer_data_out;
    logic        store_en_in;
    logic [31:0] store_addr_in;
    logic [2:0]  store_width_in;
    logic [31:0] store_data_in;
    logic        store_done_out;
    logic        io_buffer_full_in;
    logic [31:0] mem_a_out;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_wr_out;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .rob_rst_in        (rob_rst_in),
        .ifetch_en_in      (ifetch_en_in),
        .ifetch_addr_in    (ifetch_addr_in),
        .ifetch_done_out   (ifetch_done_out),
        .ifetch_data_out   (ifetch_data_out),
        .lbuffer_en_in     (lbuffer_en_in),
        .lbuffer_addr_in   (lbuffer_addr_in),
        .lbuffer_width_in  (lbuffer_width_in),
        .lbuffer_sgn_in    (lbuffer_sgn_in),
        .lbuffer_done_out  (lbuffer_done_out),
        .lbuffer_data_out  (lbuffer_data_out),
        .store_en_in       (store_en_in),
        .store_addr_in     (store_addr_in),
        .store_width_in    (store_width_in),
        .store_data_in     (store_data_in),
        .store_done_out    (store_done_out),
        .io_buffer_full_in (io_buffer_full_in),
        .mem_a_out         (mem_a_out),
        .mem_dout          (mem_dout),
        .mem_din           (mem_din),
        .mem_wr_out        (mem_wr_out)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  width;
        logic        sgn;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_if = 0;
    int n_ld = 0;
    int n_st = 0;
    int n_ovl = 0;

    logic [7:0]  ram [0:65535];
    logic [39:0] beats [$];

    always @(posedge clk_in) begin
        if (mem_wr_out) ram[mem_a_out[15:0]] <= mem_dout;
        mem_din <= ram[mem_a_out[15:0]];
    end

    always @(negedge clk_in) begin
        if (mem_wr_out) beats.push_back({mem_a_out, mem_dout});
        n_if += int'(ifetch_done_out);
        n_ld += int'(lbuffer_done_out);
        n_st += int'(store_done_out);
        if (int'(ifetch_done_out) + int'(lbuffer_done_out)
            + int'(store_done_out) > 1)
            n_ovl++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic int nb_of(input logic [2:0] w);
        if (w == 3'b001) return 1;
        if (w == 3'b010) return 2;
        return 4;
    endfunction

    task automatic wait_done(input int which, output int lat,
                             output logic [31:0] d);
        logic hit;
        lat = -1;
        d   = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_in);
            hit = (which == 0) ? ifetch_done_out :
                  (which == 1) ? lbuffer_done_out : store_done_out;
            if (hit) begin
                lat = i;
                d   = (which == 0) ? ifetch_data_out : lbuffer_data_out;
                break;
            end
        end
        case (which)
            0:       ifetch_en_in  = 1'b0;
            1:       lbuffer_en_in = 1'b0;
            default: store_en_in   = 1'b0;
        endcase
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          nb;
        int          b0;
        int          c_if;
        int          c_ld;
        int          c_st;
        int          ecnt;
        logic [31:0] d;
        logic [31:0] sh;
        logic [31:0] ea;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        nb  = nb_of(v.width);
        @(posedge clk_in);
        #1;
        b0   = beats.size();
        c_if = n_if;
        c_ld = n_ld;
        c_st = n_st;
        case (v.kind)
            0: begin
                ifetch_addr_in = v.addr;
                ifetch_en_in   = 1'b1;
            end
            1: begin
                lbuffer_addr_in  = v.addr;
                lbuffer_width_in = v.width;
                lbuffer_sgn_in   = v.sgn;
                lbuffer_en_in    = 1'b1;
            end
            default: begin
                store_addr_in  = v.addr;
                store_width_in = v.width;
                store_data_in  = v.data;
                store_en_in    = 1'b1;
            end
        endcase
        wait_done(v.kind, lat, d);
        chk({tag, "_lat"}, lat, v.lat);
        @(negedge clk_in);
        chk({tag, "_pulse"},
            {ifetch_done_out, lbuffer_done_out, store_done_out}, 0);
        if (v.kind == 2) begin
            chk({tag, "_nbeats"}, beats.size() - b0, nb);
            for (int k = 0; k < nb; k++) begin
                if (b0 + k < beats.size()) begin
                    sh = v.data >> (8 * k);
                    ea = v.addr + 32'(k);
                    chk({tag, "_beat"}, beats[b0+k], {ea, sh[7:0]});
                end
            end
        end else begin
            chk({tag, "_data"}, d, v.exp);
            chk({tag, "_nowr"}, beats.size() - b0, 0);
        end
        ea = v.addr + 32'(nb) - 32'd1;
        chk({tag, "_ahold"}, mem_a_out, ea);
        ecnt = (v.kind == 0) ? 100 : (v.kind == 1) ? 10 : 1;
        chk({tag, "_cnt"},
            (n_if - c_if) * 100 + (n_ld - c_ld) * 10 + (n_st - c_st), ecnt);
        chk({tag, "_ovl"}, n_ovl, 0);
    endtask

    vec_t        vt [$];
    int          lat;
    int          b0;
    int          c_if;
    int          c_ld;
    int          c_st;
    int          code;
    int          ord [$];
    logic [31:0] d;
    logic [31:0] ld_d;
    logic [31:0] if_d;

    initial begin
        vt.push_back('{2, 32'h0000_0100, 3'b100, 1'b0, 32'h1234_5678, 32'h0, 7});
        vt.push_back('{2, 32'h0000_0300, 3'b001, 1'b0, 32'h0000_0080, 32'h0, 4});
        vt.push_back('{2, 32'h0000_0400, 3'b010, 1'b0, 32'h0000_8001, 32'h0, 5});
        vt.push_back('{2, 32'hFFFF_FFFF, 3'b010, 1'b0, 32'h0000_1234, 32'h0, 5});
        vt.push_back('{2, 32'h0000_0200, 3'b100, 1'b0, 32'hDEAD_BEEF, 32'h0, 7});
        vt.push_back('{1, 32'h0000_0100, 3'b100, 1'b0, 32'h0, 32'h1234_5678, 8});
        vt.push_back('{1, 32'h0000_0300, 3'b001, 1'b1, 32'h0, 32'hFFFF_FF80, 5});
        vt.push_back('{1, 32'h0000_0300, 3'b001, 1'b0, 32'h0, 32'h0000_0080, 5});
        vt.push_back('{1, 32'h0000_0400, 3'b010, 1'b0, 32'h0, 32'h0000_8001, 6});
        vt.push_back('{1, 32'h0000_0400, 3'b010, 1'b1, 32'h0, 32'hFFFF_8001, 6});
        vt.push_back('{1, 32'h0000_0100, 3'b111, 1'b1, 32'h0, 32'h1234_5678, 8});
        vt.push_back('{1, 32'h0000_0100, 3'b010, 1'b1, 32'h0, 32'h0000_5678, 6});
        vt.push_back('{1, 32'hFFFF_FFFF, 3'b010, 1'b0, 32'h0, 32'h0000_1234, 6});
        vt.push_back('{1, 32'h0000_0200, 3'b100, 1'b1, 32'h0, 32'hDEAD_BEEF, 8});
        vt.push_back('{0, 32'h0000_0200, 3'b100, 1'b0, 32'h0, 32'hDEAD_BEEF, 8});
        vt.push_back('{2, 32'h0000_0500, 3'b000, 1'b0, 32'hA1B2_C3D4, 32'h0, 7});
        vt.push_back('{1, 32'h0000_0502, 3'b001, 1'b1, 32'h0, 32'hFFFF_FFB2, 5});

        rst_in            = 1'b0;
        rdy_in            = 1'b1;
        rob_rst_in        = 1'b0;
        ifetch_en_in      = 1'b0;
        ifetch_addr_in    = '0;
        lbuffer_en_in     = 1'b1;
        lbuffer_addr_in   = 32'h100;
        lbuffer_width_in  = 3'b100;
        lbuffer_sgn_in    = 1'b0;
        store_en_in       = 1'b1;
        store_addr_in     = 32'h100;
        store_width_in    = 3'b100;
        store_data_in     = 32'hFFFF_FFFF;
        io_buffer_full_in = 1'b0;

        // Reset holds everything at zero even with requests asserted.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_if_done", ifetch_done_out, 0);
        chk("rst_ld_done", lbuffer_done_out, 0);
        chk("rst_st_done", store_done_out, 0);
        chk("rst_if_data", ifetch_data_out, 0);
        chk("rst_ld_data", lbuffer_data_out, 0);
        chk("rst_mem_a", mem_a_out, 0);
        chk("rst_mem_wr", mem_wr_out, 0);
        lbuffer_en_in = 1'b0;
        store_en_in   = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("idle_mem_wr", mem_wr_out, 0);

        foreach (vt[i]) run_vec(vt[i], i);

        // Simultaneous requests: store, then load, then fetch.
        @(posedge clk_in);
        #1;
        c_if = n_if;
        c_ld = n_ld;
        c_st = n_st;
        store_addr_in    = 32'h240;
        store_width_in   = 3'b001;
        store_data_in    = 32'h5A;
        lbuffer_addr_in  = 32'h100;
        lbuffer_width_in = 3'b100;
        lbuffer_sgn_in   = 1'b0;
        ifetch_addr_in   = 32'h200;
        store_en_in      = 1'b1;
        lbuffer_en_in    = 1'b1;
        ifetch_en_in     = 1'b1;
        ld_d = '0;
        if_d = '0;
        for (int i = 0; i < 60 && ord.size() < 3; i++) begin
            @(negedge clk_in);
            if (store_done_out) begin
                ord.push_back(2);
                store_en_in = 1'b0;
            end
            if (lbuffer_done_out) begin
                ord.push_back(1);
                ld_d = lbuffer_data_out;
                lbuffer_en_in = 1'b0;
            end
            if (ifetch_done_out) begin
                ord.push_back(0);
                if_d = ifetch_data_out;
                ifetch_en_in = 1'b0;
            end
        end
        store_en_in   = 1'b0;
        lbuffer_en_in = 1'b0;
        ifetch_en_in  = 1'b0;
        repeat (2) @(negedge clk_in);
        code = 0;
        foreach (ord[i]) code = code * 10 + ord[i];
        chk("prio_order", code, 210);
        chk("prio_ld_data", ld_d, 32'h1234_5678);
        chk("prio_if_data", if_d, 32'hDEAD_BEEF);
        chk("prio_cnt",
            (n_if - c_if) * 100 + (n_ld - c_ld) * 10 + (n_st - c_st), 111);
        chk("prio_ovl", n_ovl, 0);

        // Flush mid-fetch: no fetch done; store raised after grant follows.
        @(posedge clk_in);
        #1;
        c_if = n_if;
        c_st = n_st;
        b0   = beats.size();
        ifetch_addr_in = 32'h100;
        ifetch_en_in   = 1'b1;
        @(posedge clk_in);
        #1;
        store_addr_in  = 32'h250;
        store_width_in = 3'b001;
        store_data_in  = 32'hC3;
        store_en_in    = 1'b1;
        @(posedge clk_in);
        #1;
        rob_rst_in   = 1'b1;
        ifetch_en_in = 1'b0;
        @(posedge clk_in);
        #1 rob_rst_in = 1'b0;
        wait_done(2, lat, d);
        chk("flushf_st_lat", lat, 4);
        repeat (8) @(negedge clk_in);
        chk("flushf_no_if", n_if - c_if, 0);
        chk("flushf_st_cnt", n_st - c_st, 1);
        chk("flushf_nbeats", beats.size() - b0, 1);
        if (beats.size() > b0)
            chk("flushf_beat", beats[b0], {32'h250, 8'hC3});

        // Flush while idle blocks a load grant for that edge.
        @(posedge clk_in);
        #1;
        lbuffer_addr_in  = 32'h300;
        lbuffer_width_in = 3'b001;
        lbuffer_sgn_in   = 1'b1;
        lbuffer_en_in    = 1'b1;
        rob_rst_in       = 1'b1;
        @(posedge clk_in);
        #1 rob_rst_in = 1'b0;
        wait_done(1, lat, d);
        chk("flushi_lat", lat, 5);
        chk("flushi_data", d, 32'hFFFF_FF80);

        // Flush during a store does not abort it.
        @(posedge clk_in);
        #1;
        c_st = n_st;
        b0   = beats.size();
        store_addr_in  = 32'h600;
        store_width_in = 3'b100;
        store_data_in  = 32'hCAFE_F00D;
        store_en_in    = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rob_rst_in = 1'b1;
        @(posedge clk_in);
        #1 rob_rst_in = 1'b0;
        wait_done(2, lat, d);
        chk("flushs_lat", lat, 4);
        @(negedge clk_in);
        chk("flushs_cnt", n_st - c_st, 1);
        chk("flushs_nbeats", beats.size() - b0, 4);
        if (beats.size() >= b0 + 4) begin
            chk("flushs_b0", beats[b0],   {32'h600, 8'h0D});
            chk("flushs_b3", beats[b0+3], {32'h603, 8'hCA});
        end

        // rdy_in low for 3 cycles mid-load stretches latency by 3.
        @(posedge clk_in);
        #1;
        c_ld = n_ld;
        lbuffer_addr_in  = 32'h100;
        lbuffer_width_in = 3'b100;
        lbuffer_sgn_in   = 1'b0;
        lbuffer_en_in    = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rdy_in = 1'b1;
        wait_done(1, lat, d);
        chk("rdy_lat", lat, 6);
        chk("rdy_data", d, 32'h1234_5678);
        @(negedge clk_in);
        chk("rdy_cnt", n_ld - c_ld, 1);

        // IO-region byte store with the UART buffer full for 3 cycles.
        @(posedge clk_in);
        #1;
        b0 = beats.size();
        store_addr_in     = 32'h0003_0000;
        store_width_in    = 3'b001;
        store_data_in     = 32'h77;
        store_en_in       = 1'b1;
        io_buffer_full_in = 1'b1;
`ifdef MEM_ARBITER_IO_STALL_EN
        repeat (4) begin
            @(negedge clk_in);
            chk("io_stall_wr", mem_wr_out, 0);
        end
        @(posedge clk_in);
        #1 io_buffer_full_in = 1'b0;
        wait_done(2, lat, d);
        chk("io_lat", lat, 3);
`else
        wait_done(2, lat, d);
        chk("io_lat", lat, 4);
        io_buffer_full_in = 1'b0;
`endif
        @(negedge clk_in);
        chk("io_nbeats", beats.size() - b0, 1);
        if (beats.size() > b0)
            chk("io_beat", beats[b0], {32'h0003_0000, 8'h77});
        chk("final_ovl", n_ovl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
